// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, opcode/funct constants and the ALUOp codes understood by ALUControl.
package mips_multicycle_control_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMRD    = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWR    = 5'd5,
    S_RTYPE_EX = 5'd6,
    S_RTYPE_WB = 5'd7,
    S_ADDI_EX  = 5'd8,
    S_ORI_EX   = 5'd9,
    S_ITYPE_WB = 5'd10,
    S_BEQ      = 5'd11,
    S_BNE      = 5'd12,
    S_JUMP     = 5'd13,
    S_JAL      = 5'd14,
    S_JR       = 5'd15,
    S_LUI      = 5'd16,
    S_ILLEGAL  = 5'd17
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_OR    = 3'd3;

  // Maps the instruction fields seen in DECODE to the first execute state.
  function automatic state_t decodeState(input logic [5:0] op, input logic [5:0] funct);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = (funct == FUNCT_JR) ? S_JR : S_RTYPE_EX;
      OP_BEQ:       s = S_BEQ;
      OP_BNE:       s = S_BNE;
      OP_ADDI:      s = S_ADDI_EX;
      OP_ORI:       s = S_ORI_EX;
      OP_LUI:       s = S_LUI;
      OP_J:         s = S_JUMP;
      OP_JAL:       s = S_JAL;
      default:      s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_event_counter.sv
// Free-running wrap-around event counter used for CPI measurement.
module event_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Clear on reset, otherwise advance by one on every qualifying cycle.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and
// write-back for the shared-ALU / unified-memory MIPS datapath, and keeps
// cycle and retired-instruction counters.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic [5:0]           funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 BranchNE,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           MemToReg,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 IllegalInstr,
  output logic [CNT_WIDTH-1:0] CycleCount,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  state_t state;
  state_t nextState;

  logic pcWriteRaw;
  logic pcWriteCondRaw;
  logic memWriteRaw;
  logic irWriteRaw;
  logic regWriteRaw;
  logic illegalRaw;
  logic instrFetched;

  // The branch decision is made by the datapath; Zero is not needed here.
  logic unusedZero;
  assign unusedZero = Zero;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= nextState;
  end

  // Next-state and Moore outputs; handshake-qualified enables use MemReady.
  always_comb begin
    nextState      = S_FETCH;
    pcWriteRaw     = 1'b0;
    pcWriteCondRaw = 1'b0;
    BranchNE       = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    memWriteRaw    = 1'b0;
    irWriteRaw     = 1'b0;
    MemToReg       = 2'd0;
    RegDst         = 2'd0;
    regWriteRaw    = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'd0;
    ALUOp          = ALUOP_ADD;
    PCSource       = 2'd0;
    illegalRaw     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'd1;
        irWriteRaw = MemReady;
        pcWriteRaw = MemReady;
        nextState  = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB   = 2'd3;
        nextState = decodeState(OP, funct);
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        nextState = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD      = 1'b1;
        MemRead   = 1'b1;
        nextState = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemToReg    = 2'd1;
        regWriteRaw = MemReady;
      end
      S_MEMWR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
        nextState   = MemReady ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_RTYPE;
        nextState = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegDst      = 2'd1;
        regWriteRaw = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        nextState = S_ITYPE_WB;
      end
      S_ORI_EX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        ALUOp     = ALUOP_OR;
        nextState = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        regWriteRaw = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA        = 1'b1;
        ALUOp          = ALUOP_SUB;
        pcWriteCondRaw = 1'b1;
        PCSource       = 2'd1;
        BranchNE       = (state == S_BNE);
      end
      S_JUMP: begin
        pcWriteRaw = 1'b1;
        PCSource   = 2'd2;
      end
      S_JAL: begin
        pcWriteRaw  = 1'b1;
        PCSource    = 2'd2;
        RegDst      = 2'd2;
        MemToReg    = 2'd2;
        regWriteRaw = 1'b1;
      end
      S_JR: begin
        pcWriteRaw = 1'b1;
        PCSource   = 2'd3;
      end
      S_LUI: begin
        MemToReg    = 2'd3;
        regWriteRaw = 1'b1;
      end
      S_ILLEGAL: begin
        illegalRaw = 1'b1;
      end
      default: begin
        nextState = S_FETCH;
      end
    endcase
  end

  // No architectural write may happen while reset is being applied.
  assign PCWrite      = pcWriteRaw     & ~reset;
  assign PCWriteCond  = pcWriteCondRaw & ~reset;
  assign MemWrite     = memWriteRaw    & ~reset;
  assign IRWrite      = irWriteRaw     & ~reset;
  assign RegWrite     = regWriteRaw    & ~reset;
  assign IllegalInstr = illegalRaw     & ~reset;

  assign instrFetched = (state == S_FETCH) & MemReady;

  event_counter #(.CNT_WIDTH(CNT_WIDTH)) cycleCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .count (CycleCount)
  );

  event_counter #(.CNT_WIDTH(CNT_WIDTH)) instrCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (instrFetched),
    .count (InstrCount)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multi-cycle control FSM: the stimulus side expands
// each instruction into its expected per-cycle control words, the monitor
// compares them with the DUT on the falling edge.
module tb_mips_multicycle_control;
  import mips_multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  OP = '0;
  logic [5:0]  funct = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  MemToReg, RegDst, ALUSrcB, PCSource;
  logic        RegWrite, ALUSrcA, IllegalInstr;
  logic [2:0]  ALUOp;
  logic [31:0] CycleCount, InstrCount;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] memToReg;
    logic [1:0] regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t        exp;
    ctl_t        mask;
    logic [31:0] cyc;
    logic [31:0] ins;
    bit          chkCnt;
    string       tag;
  } entry_t;

  entry_t      sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] expCycle = 0;
  logic [31:0] expInstr = 0;

  mips_multicycle_control #(.CNT_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .OP           (OP),
    .funct        (funct),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .BranchNE     (BranchNE),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemToReg     (MemToReg),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .PCSource     (PCSource),
    .IllegalInstr (IllegalInstr),
    .CycleCount   (CycleCount),
    .InstrCount   (InstrCount)
  );

  always #5 clk = ~clk;

  // Drives one clock cycle of inputs and records what the DUT must show in it.
  task automatic driveCycle(input logic rst, input logic mr, input ctl_t w,
                            input bit instrInc, input string tag);
    entry_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    MemReady = mr;
    Zero     = 1'($urandom_range(0, 1));
    e.tag    = tag;
    if (rst) begin
      e.exp              = '0;
      e.mask             = '0;
      e.mask.pcWrite     = 1'b1;
      e.mask.pcWriteCond = 1'b1;
      e.mask.memWrite    = 1'b1;
      e.mask.irWrite     = 1'b1;
      e.mask.regWrite    = 1'b1;
      e.mask.illegal     = 1'b1;
      e.cyc              = '0;
      e.ins              = '0;
      e.chkCnt           = 1'b0;
      expCycle           = 0;
      expInstr           = 0;
    end else begin
      e.exp    = w;
      e.mask   = '1;
      e.cyc    = expCycle;
      e.ins    = expInstr;
      e.chkCnt = 1'b1;
      expCycle = expCycle + 1;
      if (instrInc) expInstr = expInstr + 1;
    end
    sb.push_back(e);
  endtask

  function automatic ctl_t fetchWord(input logic mr);
    ctl_t w = '0;
    w.memRead = 1'b1;
    w.aluSrcB = 2'd1;
    w.aluOp   = ALUOP_ADD;
    w.pcWrite = mr;
    w.irWrite = mr;
    return w;
  endfunction

  function automatic logic randMr(input bit tied);
    return tied ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  task automatic doFetch(input int fWait);
    for (int i = 0; i < fWait; i++) driveCycle(1'b0, 1'b0, fetchWord(1'b0), 1'b0, "fetchWait");
    driveCycle(1'b0, 1'b1, fetchWord(1'b1), 1'b1, "fetch");
  endtask

  task automatic doDecode(input bit tied);
    ctl_t w = '0;
    w.aluSrcB = 2'd3;
    w.aluOp   = ALUOP_ADD;
    driveCycle(1'b0, randMr(tied), w, 1'b0, "decode");
  endtask

  // Runs one complete instruction through the DUT from FETCH back to FETCH.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input int fWait, input int mWait, input bit tied);
    ctl_t w;
    logic mr;
    OP    = op;
    funct = fn;
    doFetch(fWait);
    doDecode(tied);
    w = '0;
    if (op == OP_LW || op == OP_SW) begin
      w.aluSrcA = 1'b1; w.aluSrcB = 2'd2; w.aluOp = ALUOP_ADD;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "memadr");
      w = '0;
      w.iorD = 1'b1;
      if (op == OP_LW) w.memRead = 1'b1; else w.memWrite = 1'b1;
      for (int i = 0; i < mWait; i++) driveCycle(1'b0, 1'b0, w, 1'b0, "memWait");
      driveCycle(1'b0, 1'b1, w, 1'b0, "memAccess");
      if (op == OP_LW) begin
        mr = randMr(tied);
        w = '0; w.memToReg = 2'd1; w.regWrite = mr;
        driveCycle(1'b0, mr, w, 1'b0, "memwb");
      end
    end else if (op == OP_RTYPE && fn == FUNCT_JR) begin
      w.pcWrite = 1'b1; w.pcSource = 2'd3;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "jr");
    end else if (op == OP_RTYPE) begin
      w.aluSrcA = 1'b1; w.aluOp = ALUOP_RTYPE;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "rtypeEx");
      w = '0; w.regDst = 2'd1; w.regWrite = 1'b1;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "rtypeWb");
    end else if (op == OP_ADDI || op == OP_ORI) begin
      w.aluSrcA = 1'b1; w.aluSrcB = 2'd2;
      w.aluOp = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_OR;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "itypeEx");
      w = '0; w.regWrite = 1'b1;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "itypeWb");
    end else if (op == OP_BEQ || op == OP_BNE) begin
      w.aluSrcA = 1'b1; w.aluOp = ALUOP_SUB; w.pcWriteCond = 1'b1;
      w.pcSource = 2'd1; w.branchNe = (op == OP_BNE);
      driveCycle(1'b0, randMr(tied), w, 1'b0, "branch");
    end else if (op == OP_J || op == OP_JAL) begin
      w.pcWrite = 1'b1; w.pcSource = 2'd2;
      if (op == OP_JAL) begin
        w.regDst = 2'd2; w.memToReg = 2'd2; w.regWrite = 1'b1;
      end
      driveCycle(1'b0, randMr(tied), w, 1'b0, "jump");
    end else if (op == OP_LUI) begin
      w.memToReg = 2'd3; w.regWrite = 1'b1;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "lui");
    end else begin
      w.illegal = 1'b1;
      driveCycle(1'b0, randMr(tied), w, 1'b0, "illegal");
    end
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) driveCycle(1'b1, 1'b0, '0, 1'b0, "reset");
  endtask

  // A load abandoned by reset while it is waiting in the memory-read phase.
  task automatic resetMidLw();
    ctl_t w;
    OP    = OP_LW;
    funct = 6'h00;
    doFetch(0);
    doDecode(1'b0);
    w = '0; w.aluSrcA = 1'b1; w.aluSrcB = 2'd2; w.aluOp = ALUOP_ADD;
    driveCycle(1'b0, 1'b1, w, 1'b0, "memadr");
    w = '0; w.iorD = 1'b1; w.memRead = 1'b1;
    driveCycle(1'b0, 1'b0, w, 1'b0, "memWait");
    applyReset(3);
  endtask

  // Compares one expected cycle against the DUT outputs.
  task automatic checkOutput(input entry_t e);
    ctl_t act;
    act = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalInstr};
    total++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      bad++;
      $display("[TB] FAIL %s ctl: got %h want %h (mask %h) at %0t",
               e.tag, act, e.exp, e.mask, $time);
    end
    if (e.chkCnt) begin
      total++;
      if (CycleCount !== e.cyc || InstrCount !== e.ins) begin
        bad++;
        $display("[TB] FAIL %s counters: got cyc=%0d ins=%0d want cyc=%0d ins=%0d at %0t",
                 e.tag, CycleCount, InstrCount, e.cyc, e.ins, $time);
      end
    end
  endtask

  // Monitor: one expected entry per clock cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] legalOps [10];
    logic [5:0] op;
    logic [5:0] fn;
    legalOps = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};

    applyReset(3);

    // lw, sw, add, beq, j with memory always ready: 19 cycles, 5 instructions.
    applyStimulus(OP_LW,    6'h00, 0, 0, 1'b1);
    applyStimulus(OP_SW,    6'h00, 0, 0, 1'b1);
    applyStimulus(OP_RTYPE, 6'h20, 0, 0, 1'b1);
    applyStimulus(OP_BEQ,   6'h00, 0, 0, 1'b1);
    applyStimulus(OP_J,     6'h00, 0, 0, 1'b1);

    // Slow fetch, branches, jumps, lui, ori, addi and an undecodable opcode.
    applyStimulus(OP_ADDI,  6'h00, 4, 0, 1'b0);
    applyStimulus(OP_BNE,   6'h00, 0, 0, 1'b0);
    applyStimulus(OP_BEQ,   6'h00, 0, 0, 1'b0);
    applyStimulus(OP_JAL,   6'h00, 0, 0, 1'b0);
    applyStimulus(OP_RTYPE, FUNCT_JR, 0, 0, 1'b0);
    applyStimulus(OP_LUI,   6'h00, 1, 0, 1'b0);
    applyStimulus(OP_ORI,   6'h00, 0, 0, 1'b0);
    applyStimulus(6'h3F,    6'h00, 0, 0, 1'b0);
    applyStimulus(OP_LW,    6'h00, 2, 3, 1'b0);
    applyStimulus(OP_SW,    6'h00, 0, 2, 1'b0);

    resetMidLw();

    // Randomized instruction stream with random memory stalls.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
      else op = legalOps[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? FUNCT_JR : 6'($urandom_range(0, 63));
      applyStimulus(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
